// File: rtl/coproc_rom_arbiter.sv
// ROM-port arbiter for cartridge coprocessor mappers.
// Several requesters (CPU, coprocessor fetch/data, DMA) share one SDRAM ROM read
// port. One transaction is in flight at a time. SDRAM cycles start only on CLKREF slots.
//
// Handshake: a requester raises REQ[i] with ADDR/WORD stable and holds them until
// ACK[i] pulses for one cycle. RDATA is valid in that ACK cycle and holds until
// the next ACK. A REQ still high in the cycle after ACK counts as a new request.
// A REQ dropped before the grant is never served. Once granted, a transaction
// always completes unless MAP_ACTIVE drops, which discards it without an ACK.
module coproc_rom_arbiter #(
    parameter int          NCH    = 2,
    parameter int          AW     = 23,
    parameter int          RD_LAT = 4,
    parameter int          PRIO0  = 1,
    parameter logic [3:0]  MAP_ID = 4'h7
) (
    input  logic              MCLK,
    input  logic              RST_N,
    input  logic              ENABLE,
    input  logic              CLKREF,
    input  logic [7:0]        MAP_CTRL,
    input  logic [23:0]       ROM_MASK,
    input  logic [NCH-1:0]    REQ,
    input  logic [NCH*AW-1:0] ADDR,
    input  logic [NCH-1:0]    WORD,
    output logic [NCH-1:0]    ACK,
    output logic [15:0]       RDATA,
    output logic [AW-1:0]     ROM_ADDR,
    output logic              ROM_OE_N,
    output logic              ROM_WORD,
    input  logic [15:0]       ROM_Q,
    output logic              MAP_ACTIVE,
    output logic [1:0]        dbg_state
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   win_q, rr_q, grant_idx;
    logic [AW-1:0]   addr_q, sel_addr, masked_addr;
    logic            word_q, lsb_q, sel_word;
    logic [3:0]      cnt_q;
    logic [15:0]     rdata_q;
    logic            grant, issue, capture, found;
    int              j;

    // Upper mask bits above AW and the low mapper-select nibble have no use here.
    logic unused_bits;
    assign unused_bits = ^{ROM_MASK, MAP_CTRL[3:0]};

    assign MAP_ACTIVE = (MAP_CTRL[7:4] == MAP_ID);
    assign dbg_state  = state_q;
    assign ROM_ADDR   = addr_q;
    assign ROM_WORD   = word_q;
    assign RDATA      = rdata_q;

    // Winner selection: optional fixed priority for ch0, else first requester at/after rr pointer.
    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        if (PRIO0 != 0 && REQ[0]) begin
            found = 1'b1;
        end
        for (int k = 0; k < NCH; k++) begin
            j = int'(rr_q) + k;
            if (j >= NCH) j = j - NCH;
            if (!found && REQ[j]) begin
                grant_idx = IW'(j);
                found     = 1'b1;
            end
        end
        sel_addr    = ADDR[int'(grant_idx)*AW +: AW];
        sel_word    = WORD[grant_idx];
        masked_addr = sel_addr & ROM_MASK[AW-1:0];
        // Word reads are always even-aligned on the SDRAM side.
        if (sel_word) masked_addr[0] = 1'b0;
    end

    // Next-state logic; MAP_ACTIVE low forces IDLE and suppresses every action.
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        issue   = 1'b0;
        capture = 1'b0;
        case (state_q)
            S_IDLE:  if (ENABLE && (|REQ)) begin state_d = S_ISSUE; grant = 1'b1; end
            S_ISSUE: if (CLKREF) begin state_d = S_WAIT; issue = 1'b1; end
            S_WAIT:  if (cnt_q == 4'd0) begin state_d = S_DONE; capture = 1'b1; end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (!MAP_ACTIVE) begin
            state_d = S_IDLE;
            grant   = 1'b0;
            issue   = 1'b0;
            capture = 1'b0;
        end
    end

    // Pin outputs: read strobe from the issue slot through the wait, ACK in DONE.
    always_comb begin
        ROM_OE_N = 1'b1;
        ACK      = '0;
        if (MAP_ACTIVE && ((state_q == S_ISSUE && CLKREF) || state_q == S_WAIT)) ROM_OE_N = 1'b0;
        if (MAP_ACTIVE && state_q == S_DONE) ACK[win_q] = 1'b1;
    end

    // State register.
    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Transaction latches, latency counter, read data and round-robin pointer.
    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            win_q   <= '0;
            rr_q    <= '0;
            addr_q  <= '0;
            word_q  <= 1'b0;
            lsb_q   <= 1'b0;
            cnt_q   <= 4'd0;
            rdata_q <= 16'h0000;
        end else if (!MAP_ACTIVE) begin
            win_q   <= '0;
            rr_q    <= '0;
            addr_q  <= '0;
            word_q  <= 1'b0;
            lsb_q   <= 1'b0;
            cnt_q   <= 4'd0;
            rdata_q <= 16'h0000;
        end else begin
            if (grant) begin
                win_q  <= grant_idx;
                addr_q <= masked_addr;
                word_q <= sel_word;
                lsb_q  <= sel_addr[0];
            end
            if (issue) cnt_q <= 4'(RD_LAT - 1);
            else if (state_q == S_WAIT && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
            if (capture) begin
                if (word_q) rdata_q <= ROM_Q;
                else        rdata_q <= {8'h00, lsb_q ? ROM_Q[15:8] : ROM_Q[7:0]};
            end
            if (state_q == S_DONE) begin
                if (int'(win_q) == NCH - 1) rr_q <= '0;
                else                        rr_q <= IW'(int'(win_q) + 1);
            end
        end
    end

endmodule
